// File: rtl/score_ctrl_pkg.sv
// score_ctrl_pkg: shared game-state encoding and score arithmetic for the scorekeeper and HUD draw blocks.
package score_ctrl_pkg;

    localparam int SCORE_W = 8;

    // The score draw block decodes state_set with this same encoding; ST_OVER moves the score mid-screen.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PLAY    = 2'b01,
        ST_OVER    = 2'b10,
        ST_RESPAWN = 2'b11
    } state_e;

    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] a,
        input logic [SCORE_W-1:0] b,
        input logic [SCORE_W:0]   max
    );
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > max) ? max[SCORE_W-1:0] : s[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/score_ctrl_arb.sv
// rr_arbiter: combinational round-robin grant; the requester closest at or after ptr wins.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        // Scan farthest-first so the nearest eligible index is the last one written.
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                grant = N'(1) << j;
                idx   = IW'(j);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_ctrl.sv
// score_ctrl: game scorekeeper; arbitrates hit requesters onto one saturating score adder,
// tracks lives and high score, and sequences IDLE/PLAY/RESPAWN/OVER.
module score_ctrl
    import score_ctrl_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int PTS_W      = 4,
    parameter int LIVES      = 3,
    parameter int RESPAWN_FR = 120,
    parameter int SCORE_MAX  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic                  start_btn,
    input  logic                  ship_hit,
    input  logic [NREQ-1:0]       hit_req,
    input  logic [NREQ*PTS_W-1:0] hit_pts,
    output logic [NREQ-1:0]       hit_ack,
    output logic [SCORE_W-1:0]    score,
    output logic [SCORE_W-1:0]    high_score,
    output logic [1:0]            lives,
    output logic [1:0]            state_set,
    output logic                  game_over
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(RESPAWN_FR + 1);
    localparam logic [SCORE_W:0] SMAX = (SCORE_W + 1)'(SCORE_MAX);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic [1:0]         lives_q, lives_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic               go_q, go_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               start_q;

    logic [NREQ-1:0]    grant;
    logic [IW-1:0]      g_idx;
    logic               g_valid;
    logic [PTS_W-1:0]   pts;
    logic               start_rise;
    logic               scoring;

    assign start_rise = start_btn & ~start_q;
    assign scoring    = (state_q == ST_PLAY) || (state_q == ST_RESPAWN);
    assign pts        = hit_pts[int'(g_idx)*PTS_W +: PTS_W];

    // Masking with the visible ack keeps a requester from being granted twice before it drops req.
    rr_arbiter #(.N(NREQ)) u_arb (
        .req   (hit_req & ~ack_q),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (g_idx),
        .valid (g_valid)
    );

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        go_d    = 1'b0;
        ack_d   = grant;
        ptr_d   = !g_valid ? ptr_q : (g_idx == IW'(NREQ - 1)) ? '0 : g_idx + IW'(1);
        score_d = (g_valid && scoring) ? sat_add(score_q, SCORE_W'(pts), SMAX) : score_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_PLAY;
                    score_d = '0;
                    lives_d = 2'(LIVES);
                end
            end
            ST_PLAY: begin
                if (ship_hit && lives_q > 2'd1) begin
                    state_d = ST_RESPAWN;
                    lives_d = lives_q - 2'd1;
                    cnt_d   = CW'(RESPAWN_FR);
                end else if (ship_hit) begin
                    state_d = ST_OVER;
                    lives_d = '0;
                    go_d    = 1'b1;
                end
            end
            ST_RESPAWN: begin
                if (frame_tick) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start_rise) state_d = ST_IDLE;
            end
        endcase
        // Folding in score_d captures a final hit that lands on the same edge as game over.
        high_d = (score_d > high_q) ? score_d : high_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            high_q  <= '0;
            lives_q <= '0;
            ack_q   <= '0;
            go_q    <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            high_q  <= high_d;
            lives_q <= lives_d;
            ack_q   <= ack_d;
            go_q    <= go_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            start_q <= start_btn;
        end
    end

    assign hit_ack    = ack_q;
    assign score      = score_q;
    assign high_score = high_q;
    assign lives      = lives_q;
    assign state_set  = state_q;
    assign game_over  = go_q;

endmodule
